// File: rtl/core_pkg.sv
// Shared decode definitions for the core: opcodes, instruction fields and the
// dec_branch bit layout. lui uses the I-type layout with no source registers.
package core_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_XOR   = 6'b000100;
    localparam logic [5:0] OP_SLL   = 6'b000101;
    localparam logic [5:0] OP_SRL   = 6'b000110;
    localparam logic [5:0] OP_SRA   = 6'b000111;
    localparam logic [5:0] OP_SLT   = 6'b001000;
    localparam logic [5:0] OP_SLTU  = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b100000;
    localparam logic [5:0] OP_ANDI  = 6'b100001;
    localparam logic [5:0] OP_ORI   = 6'b100010;
    localparam logic [5:0] OP_XORI  = 6'b100011;
    localparam logic [5:0] OP_SLTI  = 6'b100100;
    localparam logic [5:0] OP_SLLI  = 6'b100101;
    localparam logic [5:0] OP_SRLI  = 6'b100110;
    localparam logic [5:0] OP_JALR  = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b101000;
    localparam logic [5:0] OP_FLW   = 6'b101001;
    localparam logic [5:0] OP_LUI   = 6'b101100;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLT   = 6'b110010;
    localparam logic [5:0] OP_BGE   = 6'b110011;
    localparam logic [5:0] OP_BLTU  = 6'b110100;
    localparam logic [5:0] OP_BGEU  = 6'b110101;
    localparam logic [5:0] OP_SW    = 6'b110110;
    localparam logic [5:0] OP_FSW   = 6'b110111;

    localparam logic [6:0] BUBBLE_ALUCTL = 7'b0111011;

    localparam int BR_EQ  = 0;
    localparam int BR_NE  = 1;
    localparam int BR_LT  = 2;
    localparam int BR_GE  = 3;
    localparam int BR_LTU = 4;
    localparam int BR_GEU = 5;
    localparam int BR_DO  = 6;

    typedef struct packed {
        logic [5:0]  opcode;
        logic        ctl6;
        logic [4:0]  fa;
        logic [4:0]  fb;
        logic [14:0] imm;
    } instr_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LUI,
        CLS_BR,
        CLS_ST,
        CLS_NONE
    } instr_class_e;

    function automatic instr_class_e classify(input logic [5:0] op);
        if (!op[5])
            return CLS_R;
        if (op[5:3] == 3'b100 || op[5:2] == 4'b1010)
            return CLS_I;
        if (op == OP_LUI)
            return CLS_LUI;
        if (op[5:3] == 3'b110 && op[2:0] <= 3'd5)
            return CLS_BR;
        if (op == OP_SW || op == OP_FSW)
            return CLS_ST;
        return CLS_NONE;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file: synchronous write, combinational read,
// no internal write-to-read bypass. Entry 0 is never written.
module regfile_2r1w #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: register read with forwarding, load-use stalls, bubbles.
// Define ID_FWD_EN to forward alu_fwd from execute instead of stalling on it.
module id_stage
    import core_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            id_ready,
    input  logic            n_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_fwd,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [6:0]      aluctl,
    output logic [6:0]      dec_branch,
    output logic [4:0]      ex_rd,
    output logic            ex_we
);

    localparam int AW = $clog2(NREG);

    instr_t          ins;
    instr_class_e    cls;
    logic [4:0]      rs1_idx, rs2_idx, rd_d;
    logic            use_rs1, use_rs2, we_d, load_d;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val, imm_ext;
    logic [XLEN-1:0] op1_d, op2_d;
    logic [6:0]      br_d;
    logic            ex_load;
    logic            dep1, dep2, hazard_raw, hazard_stall;

    assign ins     = instr_t'(if_instr);
    assign cls     = classify(ins.opcode);
    assign imm_ext = {{(XLEN-15){ins.imm[14]}}, ins.imm};

    regfile_2r1w #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd[AW-1:0]),
        .wdata  (wb_data),
        .raddr1 (rs1_idx[AW-1:0]),
        .raddr2 (rs2_idx[AW-1:0]),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Later assignments override earlier ones, so these run lowest priority first.
    always_comb begin
        rs1_val = rf_rdata1;
        rs2_val = rf_rdata2;
        if (wb_we && wb_rd == rs1_idx) rs1_val = wb_data;
        if (wb_we && wb_rd == rs2_idx) rs2_val = wb_data;
`ifdef ID_FWD_EN
        if (ex_we && ex_rd == rs1_idx) rs1_val = alu_fwd;
        if (ex_we && ex_rd == rs2_idx) rs2_val = alu_fwd;
`endif
        if (rs1_idx == '0) rs1_val = '0;
        if (rs2_idx == '0) rs2_val = '0;
    end

    always_comb begin
        rs1_idx = ins.fb;
        rs2_idx = ins.imm[14:10];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        rd_d    = '0;
        we_d    = 1'b0;
        op1_d   = '0;
        op2_d   = '0;
        br_d    = '0;
        case (cls)
            CLS_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                rd_d    = ins.fa;
                we_d    = ins.fa != '0;
                op1_d   = rs1_val;
                op2_d   = rs2_val;
            end
            CLS_I: begin
                use_rs1 = 1'b1;
                rd_d    = ins.fa;
                we_d    = ins.fa != '0;
                op1_d   = rs1_val;
                op2_d   = imm_ext;
            end
            CLS_LUI: begin
                rd_d    = ins.fa;
                we_d    = ins.fa != '0;
                op2_d   = imm_ext;
            end
            CLS_BR, CLS_ST: begin
                rs1_idx = ins.fa;
                rs2_idx = ins.fb;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_d   = rs1_val;
                op2_d   = rs2_val;
                if (cls == CLS_BR)
                    br_d = {1'b1, 6'(6'd1 << ins.opcode[2:0])};
            end
            default: ;
        endcase
    end

    assign load_d = we_d && (ins.opcode == OP_LW || ins.opcode == OP_FLW);

    // x0 never creates a dependence: its operand value is constant zero.
    assign dep1 = use_rs1 && rs1_idx != '0 && ex_we && ex_rd == rs1_idx;
    assign dep2 = use_rs2 && rs2_idx != '0 && ex_we && ex_rd == rs2_idx;
`ifdef ID_FWD_EN
    assign hazard_raw = ex_load && (dep1 || dep2);
`else
    assign hazard_raw = dep1 || dep2;
`endif
    assign hazard_stall = if_valid && !flush && hazard_raw;
    assign id_ready     = n_stall && !hazard_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            op1        <= '0;
            op2        <= '0;
            aluctl     <= BUBBLE_ALUCTL;
            dec_branch <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_load    <= 1'b0;
        end else if (n_stall) begin
            if (flush || !if_valid || hazard_stall) begin
                op1        <= '0;
                op2        <= '0;
                aluctl     <= BUBBLE_ALUCTL;
                dec_branch <= '0;
                ex_rd      <= '0;
                ex_we      <= 1'b0;
                ex_load    <= 1'b0;
            end else begin
                op1        <= op1_d;
                op2        <= op2_d;
                aluctl     <= {ins.ctl6, ins.opcode};
                dec_branch <= br_d;
                ex_rd      <= rd_d;
                ex_we      <= we_d;
                ex_load    <= load_d;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the decode rules.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic        id_ready;
    logic        n_stall = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] alu_fwd = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] op1, op2;
    logic [6:0]  aluctl, dec_branch;
    logic [4:0]  ex_rd;
    logic        ex_we;

    always #5 clk = ~clk;

    id_stage #(.NREG(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .id_ready   (id_ready),
        .n_stall    (n_stall),
        .flush      (flush),
        .alu_fwd    (alu_fwd),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .op1        (op1),
        .op2        (op2),
        .aluctl     (aluctl),
        .dec_branch (dec_branch),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic        m_ex_we, m_ex_load;
    logic [4:0]  m_ex_rd;
    logic [31:0] e_op1, e_op2;
    logic [6:0]  e_aluctl, e_br;
    logic [31:0] p_op1, p_op2;
    logic [6:0]  p_aluctl, p_br;
    logic        p_we, p_load, p_ready;
    logic [4:0]  p_rd;
    logic        obs_ready;

    logic [5:0] ops [24] = '{6'd0, 6'd1, 6'd2, 6'd5, 6'd8, 6'd9, 6'd32, 6'd35, 6'd39,
                             6'd40, 6'd41, 6'd40, 6'd44, 6'd48, 6'd49, 6'd50, 6'd51,
                             6'd52, 6'd53, 6'd54, 6'd55, 6'd45, 6'd56, 6'd63};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ID_FWD_EN
        if (m_ex_we && m_ex_rd == r) return alu_fwd;
`endif
        if (wb_we && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit model_dep(input logic [4:0] s);
`ifdef ID_FWD_EN
        return s != 5'd0 && m_ex_we && m_ex_load && m_ex_rd == s;
`else
        return s != 5'd0 && m_ex_we && m_ex_rd == s;
`endif
    endfunction

    task automatic model_predict();
        int op;
        logic [4:0] s1, s2, rd;
        bit u1, u2, wr, stall;
        op = int'(if_instr[31:26]);
        rd = if_instr[24:20];
        s1 = if_instr[19:15];
        s2 = if_instr[14:10];
        u1 = 0; u2 = 0; wr = 0;
        if (op < 32) begin
            u1 = 1; u2 = 1; wr = 1;
        end else if (op <= 43) begin
            u1 = 1; wr = 1;
        end else if (op == 44) begin
            wr = 1;
        end else if (op >= 48 && op <= 55) begin
            u1 = 1; u2 = 1;
            s1 = if_instr[24:20];
            s2 = if_instr[19:15];
        end
        p_op1 = u1 ? model_read(s1) : 32'd0;
        if (op >= 32 && op <= 44) p_op2 = {{17{if_instr[14]}}, if_instr[14:0]};
        else p_op2 = u2 ? model_read(s2) : 32'd0;
        p_br = (op >= 48 && op <= 53) ? (7'h40 | (7'h01 << (op - 48))) : 7'h00;
        p_aluctl = {if_instr[25], if_instr[31:26]};
        p_we = wr && rd != 5'd0;
        p_rd = rd;
        p_load = p_we && (op == 40 || op == 41);
        stall = if_valid && !flush && ((u1 && model_dep(s1)) || (u2 && model_dep(s2)));
        p_ready = n_stall && !stall;
        if (!if_valid || flush || stall) begin
            p_op1 = 0; p_op2 = 0; p_br = 0; p_aluctl = 7'h3B;
            p_we = 0; p_rd = 0; p_load = 0;
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            e_op1 = 0; e_op2 = 0; e_aluctl = 7'h3B; e_br = 0;
            m_ex_we = 0; m_ex_rd = 0; m_ex_load = 0;
        end else begin
            if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (n_stall) begin
                e_op1 = p_op1; e_op2 = p_op2; e_aluctl = p_aluctl; e_br = p_br;
                m_ex_we = p_we; m_ex_rd = p_rd; m_ex_load = p_load;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
                                 input logic ns, input logic fl, input logic [31:0] fwd,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; n_stall = ns; flush = fl;
        alu_fwd = fwd; wb_we = we; wb_rd = wrd; wb_data = wdat;
        #1;
        model_predict();
        obs_ready = id_ready;
        if (!r) checkOutput("id_ready", 32'(id_ready), 32'(p_ready));
        @(posedge clk);
        model_commit();
        #1;
        checkOutput("op1", op1, e_op1);
        checkOutput("op2", op2, e_op2);
        checkOutput("aluctl", 32'(aluctl), 32'(e_aluctl));
        checkOutput("dec_branch", 32'(dec_branch), 32'(e_br));
        checkOutput("ex_we", 32'(ex_we), 32'(m_ex_we));
        if (m_ex_we) checkOutput("ex_rd", 32'(ex_rd), 32'(m_ex_rd));
    endtask

    function automatic logic [31:0] enc3(input logic [5:0] op, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] c);
        return {op, 1'b0, a, b, c, 10'd0};
    endfunction

    task automatic wbWrite(input logic [4:0] r, input logic [31:0] d);
        applyStimulus(0, 0, 32'd0, 1, 0, 32'd0, 1, r, d);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  rop;

        applyStimulus(1, 0, 32'd0, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(1, 0, 32'd0, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("rst_aluctl", 32'(aluctl), 32'h3B);
        checkOutput("rst_dec_branch", 32'(dec_branch), 32'h0);
        checkOutput("rst_ex_we", 32'(ex_we), 32'h0);
        checkOutput("rst_ex_rd", 32'(ex_rd), 32'h0);
        checkOutput("rst_op1", op1, 32'h0);
        checkOutput("rst_op2", op2, 32'h0);

        // add x1,x2,x3 then add x4,x1,x1 with the sum on alu_fwd
        wbWrite(5'd2, 32'd5);
        wbWrite(5'd3, 32'd7);
        applyStimulus(0, 1, enc3(6'd0, 5'd1, 5'd2, 5'd3), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("add_op1", op1, 32'd5);
        checkOutput("add_op2", op2, 32'd7);
        checkOutput("add_ex_rd", 32'(ex_rd), 32'd1);
        applyStimulus(0, 1, enc3(6'd0, 5'd4, 5'd1, 5'd1), 1, 0, 32'd12, 0, 5'd0, 32'd0);
`ifdef ID_FWD_EN
        checkOutput("fwd_ready", 32'(obs_ready), 32'd1);
`else
        checkOutput("fwd_stall_ready", 32'(obs_ready), 32'd0);
        checkOutput("fwd_bubble", 32'(aluctl), 32'h3B);
        applyStimulus(0, 1, enc3(6'd0, 5'd4, 5'd1, 5'd1), 1, 0, 32'd0, 1, 5'd1, 32'd12);
        checkOutput("fwd_wb_ready", 32'(obs_ready), 32'd1);
`endif
        checkOutput("fwd_op1", op1, 32'd12);
        checkOutput("fwd_op2", op2, 32'd12);

        // freeze for three cycles while x2 is rewritten underneath
        applyStimulus(0, 1, enc3(6'd0, 5'd7, 5'd2, 5'd3), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, enc3(6'd1, 5'd9, 5'd4, 5'd4), 0, 0, 32'd3, k == 0, 5'd2, 32'd99);
            checkOutput("freeze_op1", op1, 32'd5);
            checkOutput("freeze_op2", op2, 32'd7);
            checkOutput("freeze_rd", 32'(ex_rd), 32'd7);
        end
        applyStimulus(0, 1, enc3(6'd0, 5'd10, 5'd2, 5'd0), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("stall_write_op1", op1, 32'd99);

        // load-use
        applyStimulus(0, 1, {6'b101000, 1'b0, 5'd5, 5'd0, 15'd0}, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(0, 1, enc3(6'd0, 5'd6, 5'd5, 5'd0), 1, 0, 32'h1234, 0, 5'd0, 32'd0);
        checkOutput("lu_ready", 32'(obs_ready), 32'd0);
        checkOutput("lu_bubble", 32'(aluctl), 32'h3B);
        applyStimulus(0, 1, enc3(6'd0, 5'd6, 5'd5, 5'd0), 1, 0, 32'h1234, 1, 5'd5, 32'hDEADBEEF);
        checkOutput("lu_ready2", 32'(obs_ready), 32'd1);
        checkOutput("lu_op1", op1, 32'hDEADBEEF);
        checkOutput("lu_op2", op2, 32'd0);

        // blt x1,x2
        wbWrite(5'd1, 32'hFFFFFFFF);
        wbWrite(5'd2, 32'd1);
        applyStimulus(0, 1, {6'b110010, 1'b0, 5'd1, 5'd2, 15'd0}, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("blt_dec", 32'(dec_branch), 32'h44);
        checkOutput("blt_op1", op1, 32'hFFFFFFFF);
        checkOutput("blt_op2", op2, 32'd1);
        checkOutput("blt_ex_we", 32'(ex_we), 32'd0);

        applyStimulus(0, 1, enc3(6'd0, 5'd11, 5'd2, 5'd3), 1, 1, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("flush_ready", 32'(obs_ready), 32'd1);
        checkOutput("flush_ex_we", 32'(ex_we), 32'd0);
        checkOutput("flush_aluctl", 32'(aluctl), 32'h3B);

        wbWrite(5'd0, 32'h55);
        applyStimulus(0, 1, {6'b110000, 1'b0, 5'd0, 5'd0, 15'd0}, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("x0_op1", op1, 32'd0);
        checkOutput("x0_dec", 32'(dec_branch), 32'h41);

        // reset during a load-use stall
        applyStimulus(0, 1, {6'b101000, 1'b0, 5'd5, 5'd0, 15'd0}, 1, 0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(0, 1, enc3(6'd0, 5'd6, 5'd5, 5'd0), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(1, 1, enc3(6'd0, 5'd6, 5'd5, 5'd0), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        applyStimulus(0, 1, enc3(6'd0, 5'd6, 5'd5, 5'd0), 1, 0, 32'd0, 0, 5'd0, 32'd0);
        checkOutput("rst_stall_ready", 32'(obs_ready), 32'd1);
        checkOutput("rst_stall_rd", 32'(ex_rd), 32'd6);
        checkOutput("rst_stall_op1", op1, 32'd0);

        for (int n = 0; n < 800; n++) begin
            rop = ops[$urandom_range(0, 23)];
            ins = {rop, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 10'($urandom)};
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0), ins,
                          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0),
                          32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          32'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
